// File: rtl/multdiv_issue_ctrl_pkg.sv
// Shared processor definitions for the multdiv issue path.
// Holds the issue FSM encoding, the rstatus destination, the exception codes
// written to rstatus, the decode constants that produce isMul_x/isDiv_x, and
// the request/response records carried by the issue controller.
package multdiv_issue_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_BUSY  = 2'd2,
    ST_DONE  = 2'd3
  } md_state_t;

  localparam logic [4:0]  RSTATUS_REG = 5'd30;
  localparam logic [31:0] MUL_EXC     = 32'd4;
  localparam logic [31:0] DIV_EXC     = 32'd5;

  // R-type ALU opcode and the ALUop field values selecting mul/div.
  localparam logic [4:0] OPC_ALU   = 5'b00000;
  localparam logic [4:0] ALUOP_MUL = 5'b00110;
  localparam logic [4:0] ALUOP_DIV = 5'b00111;

  // Operands and destination held while multdiv runs.
  typedef struct packed {
    logic        is_div;
    logic [4:0]  rd;
    logic [31:0] a;
    logic [31:0] b;
  } md_req_t;

  // Captured writeback presented to the X/M latch.
  typedef struct packed {
    logic [31:0] res;
    logic [4:0]  rd;
    logic        exc;
  } md_rsp_t;

  function automatic logic is_mul_op(input logic [4:0] opcode, input logic [4:0] aluop);
    return (opcode == OPC_ALU) && (aluop == ALUOP_MUL);
  endfunction

  function automatic logic is_div_op(input logic [4:0] opcode, input logic [4:0] aluop);
    return (opcode == OPC_ALU) && (aluop == ALUOP_DIV);
  endfunction

  function automatic logic [31:0] exc_code(input logic is_div);
    return is_div ? DIV_EXC : MUL_EXC;
  endfunction

endpackage

// File: rtl/multdiv_watchdog.sv
// Cycle counter bounding the wait for multdiv completion.
// Ports:
//   clock, reset : rising-edge clock, async active-high reset
//   clr          : synchronous clear (wins over en)
//   en           : count one per cycle
//   tc           : count has reached MAX_CYCLES-1
module multdiv_watchdog #(
  parameter int MAX_CYCLES = 40
) (
  input  logic clock,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tc
);
  localparam int CW = $clog2(MAX_CYCLES + 1);

  logic [CW-1:0] cnt;

  // Holds at terminal count so it cannot wrap if en stays high.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)           cnt <= '0;
    else if (clr)        cnt <= '0;
    else if (en && !tc)  cnt <= cnt + 1'b1;
  end

  assign tc = (cnt == CW'(MAX_CYCLES - 1));
endmodule

// File: rtl/multdiv_issue_ctrl.sv
// Issue controller between X and the multi-cycle multdiv unit.
// Latches operands/destination for a mul/div in X, pulses ctrl_MULT/ctrl_DIV
// for one cycle, stalls the front end until data_resultRDY, then presents the
// result (or an rstatus exception write) to the X/M latch for one cycle.
// Ports:
//   clock, reset                   : rising-edge clock, async active-high reset
//   isMul_x, isDiv_x, rd_x, flush  : X-stage decode, destination, squash
//   operand_a, operand_b           : bypassed ALU inputs
//   data_resultRDY/exception/result: multdiv completion interface
//   ctrl_MULT, ctrl_DIV            : one-cycle start pulses
//   data_a, data_b                 : held operands to multdiv
//   isStillMultDiv                 : stall for PC, F/D, D/X
//   result_valid, result, result_rd, exception : writeback to X/M
//   timeout                        : sticky watchdog flag
module multdiv_issue_ctrl #(
  parameter int         MAX_CYCLES  = 40,
  parameter logic [4:0] RSTATUS_REG = multdiv_issue_ctrl_pkg::RSTATUS_REG
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        isMul_x,
  input  logic        isDiv_x,
  input  logic [31:0] operand_a,
  input  logic [31:0] operand_b,
  input  logic [4:0]  rd_x,
  input  logic        flush,
  input  logic        data_resultRDY,
  input  logic        data_exception,
  input  logic [31:0] data_result,
  output logic        ctrl_MULT,
  output logic        ctrl_DIV,
  output logic [31:0] data_a,
  output logic [31:0] data_b,
  output logic        isStillMultDiv,
  output logic        result_valid,
  output logic [31:0] result,
  output logic [4:0]  result_rd,
  output logic        exception,
  output logic        timeout
);
  import multdiv_issue_ctrl_pkg::*;

  md_state_t state, state_nxt;
  md_req_t   req_q;
  md_rsp_t   rsp_q;
  logic      timeout_q;

  logic request, accept, capture, cap_exc, to_fire, wd_tc;

  assign request = (isMul_x | isDiv_x) & ~flush;

  multdiv_watchdog #(.MAX_CYCLES(MAX_CYCLES)) u_wd (
    .clock (clock),
    .reset (reset),
    .clr   (state != ST_BUSY),
    .en    (state == ST_BUSY),
    .tc    (wd_tc)
  );

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    capture   = 1'b0;
    cap_exc   = 1'b0;
    to_fire   = 1'b0;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (request) begin
          accept    = 1'b1;
          state_nxt = ST_START;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      // RDY is not looked at here: multdiv cannot finish in the pulse cycle.
      ST_START: state_nxt = flush ? ST_IDLE : ST_BUSY;
      ST_BUSY: begin
        // Flush beats a same-cycle RDY; completion beats the watchdog.
        if (flush) begin
          state_nxt = ST_IDLE;
        end else if (data_resultRDY) begin
          capture   = 1'b1;
          cap_exc   = data_exception;
          state_nxt = ST_DONE;
        end else if (wd_tc) begin
          capture   = 1'b1;
          cap_exc   = 1'b1;
          to_fire   = 1'b1;
          state_nxt = ST_DONE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      req_q     <= '0;
      rsp_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        req_q.is_div <= ~isMul_x;  // mul wins when both decode bits are set
        req_q.rd     <= rd_x;
        req_q.a      <= operand_a;
        req_q.b      <= operand_b;
      end
      if (capture) begin
        if (cap_exc) begin
          rsp_q.res <= exc_code(req_q.is_div);
          rsp_q.rd  <= RSTATUS_REG;
          rsp_q.exc <= 1'b1;
        end else begin
          rsp_q.res <= data_result;
          rsp_q.rd  <= req_q.rd;
          rsp_q.exc <= 1'b0;
        end
      end
      if (to_fire) timeout_q <= 1'b1;
    end
  end

  assign ctrl_MULT    = (state == ST_START) & ~req_q.is_div;
  assign ctrl_DIV     = (state == ST_START) &  req_q.is_div;
  assign data_a       = req_q.a;
  assign data_b       = req_q.b;
  assign result_valid = (state == ST_DONE);
  assign result       = rsp_q.res;
  assign result_rd    = rsp_q.rd;
  assign exception    = rsp_q.exc;
  assign timeout      = timeout_q;

  // The request term is combinational from X, so mask it while reset is held
  // to keep every output low for the whole reset window.
  assign isStillMultDiv = ~reset &
    ((request & ((state == ST_IDLE) | (state == ST_DONE))) |
     (state == ST_START) | (state == ST_BUSY));
endmodule
